// File: rtl/udma_stream_pkg.sv
// Shared types for the uDMA stream replay unit.
// FSM states, jump queue entry and beat increment helper.
package udma_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REPLAY,
        ST_DRAIN
    } state_e;

    // Jump entries are stored at a fixed width and narrowed by the user.
    localparam int unsigned JUMP_AW = 32;

    typedef struct packed {
        logic [JUMP_AW-1:0] src;
        logic [JUMP_AW-1:0] dst;
    } jump_entry_t;

    function automatic logic [2:0] ds_to_inc(input logic [1:0] ds);
        logic [2:0] inc;
        unique case (ds)
            2'b00:   inc = 3'd1;
            2'b01:   inc = 3'd2;
            2'b10:   inc = 3'd4;
            default: inc = 3'd0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/udma_stream_sync_fifo.sv
// Synchronous show-ahead FIFO with count/full/empty.
// Push while full is accepted only together with a pop.
module udma_stream_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    rp_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem[rp_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wp_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wp_q <= wrap_inc(wp_q);
            end
            if (do_pop) begin
                rp_q <= wrap_inc(rp_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/udma_stream_replay.sv
// uDMA stream replay: snoops spoofed L2 writes, replays them via TX.
// Passes the input stream through while idle.
module udma_stream_replay
    import udma_stream_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL  = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STREAM_ID_WIDTH = 2,
    parameter int unsigned INST_ID         = 0,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned JUMP_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_clr_i,
    input  logic                       cmd_stop_i,
    output logic                       tx_ch_req_o,
    input  logic                       tx_ch_gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0]  tx_ch_addr_o,
    output logic [1:0]                 tx_ch_datasize_o,
    input  logic                       tx_ch_valid_i,
    output logic                       tx_ch_ready_o,
    input  logic [DATA_WIDTH-1:0]      tx_ch_data_i,
    input  logic [STREAM_ID_WIDTH-1:0] in_stream_dest_i,
    input  logic [DATA_WIDTH-1:0]      in_stream_data_i,
    input  logic [1:0]                 in_stream_datasize_i,
    input  logic                       in_stream_valid_i,
    input  logic                       in_stream_sot_i,
    input  logic                       in_stream_eot_i,
    output logic                       in_stream_ready_o,
    output logic [DATA_WIDTH-1:0]      out_stream_data_o,
    output logic [1:0]                 out_stream_datasize_o,
    output logic                       out_stream_valid_o,
    output logic                       out_stream_sot_o,
    output logic                       out_stream_eot_o,
    input  logic                       out_stream_ready_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  spoof_addr_i,
    input  logic [STREAM_ID_WIDTH-1:0] spoof_dest_i,
    input  logic [1:0]                 spoof_datasize_i,
    input  logic                       spoof_req_i,
    input  logic                       spoof_gnt_i,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned AW = L2_AWIDTH_NOAL;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned JW = $clog2(JUMP_DEPTH + 1);
    localparam logic [STREAM_ID_WIDTH-1:0] MY_ID = STREAM_ID_WIDTH'(INST_ID);

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [1:0]      r_ds_q;
    logic [CW-1:0]   out_cnt_q;
    logic            pend_sot_q;
    logic            err_q;

    logic            clr;
    logic            active;
    logic            wr_ev;
    logic [AW-1:0]   w_next;
    logic [AW-1:0]   nxt;
    logic [CW:0]     credit;
    logic            gnt_ev;
    logic            jp_want;
    logic            jq_push;
    logic            jq_pop;
    logic            bypass;
    logic            rd_valid;
    logic            out_hs;
    logic            ptr_eq;
    logic            eot_cond;
    logic            err_set;

    jump_entry_t     jq_in;
    jump_entry_t     jq_head;
    logic [JW-1:0]   jq_count;
    logic            jq_full;
    logic            jq_empty;

    logic [DATA_WIDTH-1:0] df_data;
    logic [CW-1:0]   df_count;
    logic            df_full;
    logic            df_empty;
    logic            unused_ok;

    assign clr      = rst_i | cmd_clr_i;
    assign active   = (state_q != ST_IDLE);
    assign wr_ev    = spoof_req_i & spoof_gnt_i & (spoof_dest_i == MY_ID);
    assign w_next   = spoof_addr_i + AW'(ds_to_inc(spoof_datasize_i));
    assign nxt      = rd_ptr_q + AW'(ds_to_inc(r_ds_q));
    assign ptr_eq   = (rd_ptr_q == wr_ptr_q);
    assign credit   = {1'b0, out_cnt_q} + {1'b0, df_count};

    assign tx_ch_req_o = active & ~ptr_eq
                       & (credit < (CW+1)'(FIFO_DEPTH));
    assign gnt_ev   = tx_ch_req_o & tx_ch_gnt_i;

    assign jp_want  = active & wr_ev & (spoof_addr_i != wr_ptr_q);
    assign jq_pop   = gnt_ev & ~jq_empty
                    & (jq_head.src == JUMP_AW'(nxt));
    assign bypass   = gnt_ev & jq_empty & jp_want & (nxt == wr_ptr_q);
    assign jq_push  = jp_want & ~bypass;
    assign jq_in.src = JUMP_AW'(wr_ptr_q);
    assign jq_in.dst = JUMP_AW'(spoof_addr_i);

    assign rd_valid = active & tx_ch_valid_i & (out_cnt_q != '0);
    assign out_hs   = active & ~df_empty & out_stream_ready_i;
    assign eot_cond = (state_q == ST_DRAIN) & ptr_eq
                    & (out_cnt_q == '0) & (df_count == CW'(1));

    assign err_set  = (wr_ev & (spoof_datasize_i == 2'b11))
                    | (active & wr_ev & (spoof_datasize_i != r_ds_q))
                    | (jq_push & jq_full & ~jq_pop)
                    | (active & tx_ch_valid_i & (out_cnt_q == '0))
                    | (rd_valid & df_full & ~out_hs);

    assign tx_ch_addr_o     = rd_ptr_q;
    assign tx_ch_datasize_o = r_ds_q;
    assign tx_ch_ready_o    = active;
    assign busy_o           = active;
    assign err_o            = err_q;
    assign unused_ok        = ^{jq_count, jq_head.dst};

    udma_stream_sync_fifo #(
        .WIDTH ($bits(jump_entry_t)),
        .DEPTH (JUMP_DEPTH),
        .CW    (JW)
    ) u_jump_q (
        .clk_i   (clk_i),
        .rst_i   (clr),
        .push_i  (jq_push),
        .data_i  (jq_in),
        .pop_i   (jq_pop),
        .data_o  (jq_head),
        .count_o (jq_count),
        .full_o  (jq_full),
        .empty_o (jq_empty)
    );

    udma_stream_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_data_q (
        .clk_i   (clk_i),
        .rst_i   (clr),
        .push_i  (rd_valid),
        .data_i  (tx_ch_data_i),
        .pop_i   (out_hs),
        .data_o  (df_data),
        .count_o (df_count),
        .full_o  (df_full),
        .empty_o (df_empty)
    );

    // Next state: start on a write, drain on stop, idle when drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_ev) begin
                    state_d = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (cmd_stop_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ptr_eq && out_cnt_q == '0 && df_empty) begin
                    state_d = ST_IDLE;
                end else if (out_hs && eot_cond) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointers, credit counter and sticky error.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            r_ds_q     <= '0;
            out_cnt_q  <= '0;
            pend_sot_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (!active) begin
                if (wr_ev) begin
                    r_ds_q     <= spoof_datasize_i;
                    rd_ptr_q   <= spoof_addr_i;
                    wr_ptr_q   <= w_next;
                    pend_sot_q <= 1'b1;
                end
            end else begin
                if (wr_ev) begin
                    wr_ptr_q <= w_next;
                end
                if (gnt_ev) begin
                    if (jq_pop) begin
                        rd_ptr_q <= AW'(jq_head.dst);
                    end else if (bypass) begin
                        rd_ptr_q <= spoof_addr_i;
                    end else begin
                        rd_ptr_q <= nxt;
                    end
                end
                if (out_hs) begin
                    pend_sot_q <= 1'b0;
                end
            end
            unique case ({gnt_ev, rd_valid})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // Output stream mux: replay FIFO when active, passthrough when idle.
    always_comb begin
        out_stream_data_o     = '0;
        out_stream_datasize_o = '0;
        out_stream_valid_o    = 1'b0;
        out_stream_sot_o      = 1'b0;
        out_stream_eot_o      = 1'b0;
        in_stream_ready_o     = 1'b0;
        if (active) begin
            out_stream_data_o     = df_data;
            out_stream_datasize_o = r_ds_q;
            out_stream_valid_o    = ~df_empty;
            out_stream_sot_o      = pend_sot_q & ~df_empty;
            out_stream_eot_o      = eot_cond;
        end else begin
            in_stream_ready_o = out_stream_ready_i;
            if (in_stream_dest_i == MY_ID) begin
                out_stream_data_o     = in_stream_data_i;
                out_stream_datasize_o = in_stream_datasize_i;
                out_stream_valid_o    = in_stream_valid_i;
                out_stream_sot_o      = in_stream_sot_i;
                out_stream_eot_o      = in_stream_eot_i;
            end
        end
    end

endmodule

// File: tb/tb_udma_stream_replay.sv
// Directed bench for udma_stream_replay.
// Second instance with a single-entry jump queue for overflow.
module tb_udma_stream_replay;

    logic        clk = 1'b0;
    logic        rst, clr, stop;
    logic        tx_gnt, tx_valid;
    logic [31:0] tx_data;
    logic [1:0]  in_dest, in_ds;
    logic [31:0] in_data;
    logic        in_valid, in_sot, in_eot;
    logic        out_ready;
    logic [15:0] sp_addr;
    logic [1:0]  sp_dest, sp_ds;
    logic        sp_req, sp_gnt;

    logic        tx_req, tx_ready, in_ready;
    logic [15:0] tx_addr;
    logic [1:0]  tx_ds, out_ds;
    logic [31:0] out_data;
    logic        out_valid, out_sot, out_eot, busy, err;

    logic        tx_req_b, tx_ready_b, in_ready_b;
    logic [15:0] tx_addr_b;
    logic [1:0]  tx_ds_b, out_ds_b;
    logic [31:0] out_data_b;
    logic        out_valid_b, out_sot_b, out_eot_b, busy_b, err_b;

    int checks   = 0;
    int failures = 0;
    int grants;

    always #5 clk = ~clk;

    udma_stream_replay dut (
        .clk_i(clk), .rst_i(rst), .cmd_clr_i(clr), .cmd_stop_i(stop),
        .tx_ch_req_o(tx_req), .tx_ch_gnt_i(tx_gnt),
        .tx_ch_addr_o(tx_addr), .tx_ch_datasize_o(tx_ds),
        .tx_ch_valid_i(tx_valid), .tx_ch_ready_o(tx_ready),
        .tx_ch_data_i(tx_data),
        .in_stream_dest_i(in_dest), .in_stream_data_i(in_data),
        .in_stream_datasize_i(in_ds), .in_stream_valid_i(in_valid),
        .in_stream_sot_i(in_sot), .in_stream_eot_i(in_eot),
        .in_stream_ready_o(in_ready),
        .out_stream_data_o(out_data), .out_stream_datasize_o(out_ds),
        .out_stream_valid_o(out_valid), .out_stream_sot_o(out_sot),
        .out_stream_eot_o(out_eot), .out_stream_ready_i(out_ready),
        .spoof_addr_i(sp_addr), .spoof_dest_i(sp_dest),
        .spoof_datasize_i(sp_ds), .spoof_req_i(sp_req),
        .spoof_gnt_i(sp_gnt), .busy_o(busy), .err_o(err)
    );

    udma_stream_replay #(.JUMP_DEPTH(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_clr_i(clr), .cmd_stop_i(stop),
        .tx_ch_req_o(tx_req_b), .tx_ch_gnt_i(tx_gnt),
        .tx_ch_addr_o(tx_addr_b), .tx_ch_datasize_o(tx_ds_b),
        .tx_ch_valid_i(tx_valid), .tx_ch_ready_o(tx_ready_b),
        .tx_ch_data_i(tx_data),
        .in_stream_dest_i(in_dest), .in_stream_data_i(in_data),
        .in_stream_datasize_i(in_ds), .in_stream_valid_i(in_valid),
        .in_stream_sot_i(in_sot), .in_stream_eot_i(in_eot),
        .in_stream_ready_o(in_ready_b),
        .out_stream_data_o(out_data_b), .out_stream_datasize_o(out_ds_b),
        .out_stream_valid_o(out_valid_b), .out_stream_sot_o(out_sot_b),
        .out_stream_eot_o(out_eot_b), .out_stream_ready_i(out_ready),
        .spoof_addr_i(sp_addr), .spoof_dest_i(sp_dest),
        .spoof_datasize_i(sp_ds), .spoof_req_i(sp_req),
        .spoof_gnt_i(sp_gnt), .busy_o(busy_b), .err_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a);
        sp_addr = a;
        sp_ds   = 2'b10;
        sp_dest = 2'd0;
        sp_req  = 1'b1;
        sp_gnt  = 1'b1;
        tick();
        sp_req  = 1'b0;
        sp_gnt  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; stop = 1'b0;
        tx_gnt = 1'b0; tx_valid = 1'b0; tx_data = '0;
        in_dest = '0; in_ds = '0; in_data = '0;
        in_valid = 1'b0; in_sot = 1'b0; in_eot = 1'b0;
        out_ready = 1'b0;
        sp_addr = '0; sp_dest = '0; sp_ds = '0;
        sp_req = 1'b0; sp_gnt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_req", tx_req, 0);
        chk("rst_addr", tx_addr, 0);
        chk("rst_ds", tx_ds, 0);
        chk("rst_txready", tx_ready, 0);
        chk("rst_outvalid", out_valid, 0);

        // idle passthrough
        in_valid = 1'b1; in_sot = 1'b1; in_data = 32'hAA55_1234;
        in_ds = 2'b01; out_ready = 1'b1; #1;
        chk("pt_valid", out_valid, 1);
        chk("pt_data", out_data, 32'hAA55_1234);
        chk("pt_sot", out_sot, 1);
        chk("pt_ds", out_ds, 2'b01);
        chk("pt_ready", in_ready, 1);
        in_dest = 2'd1; out_ready = 1'b0; #1;
        chk("pt_gate_valid", out_valid, 0);
        chk("pt_gate_data", out_data, 0);
        chk("pt_ready_lo", in_ready, 0);
        in_valid = 1'b0; in_sot = 1'b0; in_dest = 2'd0;
        in_data = '0; in_ds = '0;

        // contiguous writes
        wr(16'h0100); wr(16'h0104); wr(16'h0108);
        chk("c_busy", busy, 1);
        chk("c_inready", in_ready, 0);
        chk("c_req", tx_req, 1);
        chk("c_ds", tx_ds, 2'b10);
        tx_gnt = 1'b1;
        chk("c_addr0", tx_addr, 16'h0100);
        tick();
        chk("c_addr1", tx_addr, 16'h0104);
        tick();
        chk("c_addr2", tx_addr, 16'h0108);
        tick();
        tx_gnt = 1'b0;
        chk("c_req_done", tx_req, 0);
        out_ready = 1'b1;
        tx_valid = 1'b1; tx_data = 32'hD000_0000;
        tick();
        tx_data = 32'hD000_0001;
        chk("c_v0", out_valid, 1);
        chk("c_d0", out_data, 32'hD000_0000);
        chk("c_sot0", out_sot, 1);
        chk("c_ods0", out_ds, 2'b10);
        tick();
        tx_data = 32'hD000_0002;
        chk("c_d1", out_data, 32'hD000_0001);
        chk("c_sot1", out_sot, 0);
        tick();
        tx_valid = 1'b0;
        chk("c_d2", out_data, 32'hD000_0002);
        chk("c_sot2", out_sot, 0);
        chk("c_eot2", out_eot, 0);
        tick();
        chk("c_empty", out_valid, 0);
        chk("c_err", err, 0);
        chk("c_busy_hold", busy, 1);
        out_ready = 1'b0;
        do_clr();
        chk("c_clr_busy", busy, 0);

        // discontinuity
        wr(16'h0100); wr(16'h0104); wr(16'h0200);
        tx_gnt = 1'b1;
        chk("j_addr0", tx_addr, 16'h0100);
        tick();
        chk("j_addr1", tx_addr, 16'h0104);
        tick();
        chk("j_addr2", tx_addr, 16'h0200);
        tick();
        tx_gnt = 1'b0;
        chk("j_req_done", tx_req, 0);
        chk("j_err", err, 0);
        do_clr();
        chk("j_txready", tx_ready, 0);

        // clear during a grant
        wr(16'h0100); wr(16'h0104);
        tx_gnt = 1'b1; clr = 1'b1; #1;
        chk("k_req_pre", tx_req, 1);
        tick();
        tx_gnt = 1'b0; clr = 1'b0;
        chk("k_busy", busy, 0);
        chk("k_addr", tx_addr, 0);
        chk("k_req", tx_req, 0);

        // credit limit under backpressure
        for (int i = 0; i < 8; i++) begin
            wr(16'h0100 + 16'(4 * i));
        end
        tx_gnt = 1'b1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_req) grants++;
            tick();
        end
        tx_gnt = 1'b0;
        chk("b_grants", grants, 4);
        chk("b_addr", tx_addr, 16'h0110);
        tx_valid = 1'b1; tx_data = 32'hB0;
        tick(); tick(); tick(); tick();
        tx_valid = 1'b0;
        chk("b_req_full", tx_req, 0);
        chk("b_valid", out_valid, 1);
        chk("b_data", out_data, 32'hB0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b_req_resume", tx_req, 1);
        chk("b_err", err, 0);
        do_clr();

        // jump queue overflow on the single-entry instance
        chk("o_err_b_pre", err_b, 0);
        wr(16'h0100); wr(16'h0200); wr(16'h0300);
        chk("o_err_b", err_b, 1);
        chk("o_err_a", err, 0);
        tick(); tick();
        chk("o_err_b_sticky", err_b, 1);
        do_clr();
        chk("o_err_b_clr", err_b, 0);

        // bypass on the last word
        wr(16'h0100); wr(16'h0104);
        tx_gnt = 1'b1;
        tick();
        chk("y_addr1", tx_addr, 16'h0104);
        sp_addr = 16'h0300; sp_ds = 2'b10; sp_dest = 2'd0;
        sp_req = 1'b1; sp_gnt = 1'b1;
        tick();
        sp_req = 1'b0; sp_gnt = 1'b0;
        chk("y_addr_byp", tx_addr, 16'h0300);
        chk("y_req", tx_req, 1);
        tick();
        tx_gnt = 1'b0;
        chk("y_addr_end", tx_addr, 16'h0304);
        chk("y_req_end", tx_req, 0);
        chk("y_err", err, 0);
        do_clr();

        // graceful stop with two reads outstanding
        wr(16'h0100); wr(16'h0104);
        tx_gnt = 1'b1;
        tick(); tick();
        tx_gnt = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s_busy", busy, 1);
        chk("s_valid0", out_valid, 0);
        out_ready = 1'b1;
        tx_valid = 1'b1; tx_data = 32'h5A00_0000;
        tick();
        tx_data = 32'h5A00_0001;
        chk("s_d0", out_data, 32'h5A00_0000);
        chk("s_sot0", out_sot, 1);
        chk("s_eot0", out_eot, 0);
        tick();
        tx_valid = 1'b0;
        chk("s_d1", out_data, 32'h5A00_0001);
        chk("s_sot1", out_sot, 0);
        chk("s_eot1", out_eot, 1);
        chk("s_busy1", busy, 1);
        tick();
        chk("s_idle", busy, 0);
        chk("s_txready", tx_ready, 0);
        chk("s_valid_idle", out_valid, 0);
        chk("s_err", err, 0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udma_stream_replay.md
Name: udma_stream_replay

Overview:
- Parametrised successor to the single-instance uDMA stream unit.
- Snoops spoofed L2 writes addressed to this instance and tracks the written region, including a queue of up to JUMP_DEPTH address discontinuities.
- Replays the written data through the TX channel with credit-bounded outstanding reads and an internal data FIFO.
- When not replaying, passes the input stream straight to the output stream; supports a graceful stop that ends replay with eot.

Parameters:
L2_AWIDTH_NOAL, 16, byte-address width; pointers wrap modulo 2^L2_AWIDTH_NOAL
DATA_WIDTH, 32, stream/TX data width
STREAM_ID_WIDTH, 2, destination ID width
INST_ID, 0, ID matched against spoof_dest_i / in_stream_dest_i
FIFO_DEPTH, 4, replay data FIFO depth (>=2); also the read credit limit
JUMP_DEPTH, 4, discontinuity queue depth (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cmd_clr_i  in  1  abort: all state cleared, back to IDLE
cmd_stop_i  in  1  pulse: drain remaining data, then end with eot
tx_ch_req_o / tx_ch_gnt_i  out/in  1  TX read request and grant
tx_ch_addr_o  out  L2_AWIDTH_NOAL  read address (equals rd_ptr)
tx_ch_datasize_o  out  2  sampled datasize
tx_ch_valid_i / tx_ch_ready_o  in/out  1  read-data handshake
tx_ch_data_i  in  DATA_WIDTH  read data
in_stream_dest_i  in  STREAM_ID_WIDTH  input stream destination
in_stream_data_i  in  DATA_WIDTH  input stream data
in_stream_datasize_i  in  2  input stream datasize
in_stream_valid_i, in_stream_sot_i, in_stream_eot_i  in  1  input stream controls
in_stream_ready_o  out  1  input stream ready
out_stream_data_o  out  DATA_WIDTH  output stream data
out_stream_datasize_o  out  2  output stream datasize
out_stream_valid_o, out_stream_sot_o, out_stream_eot_o  out  1  output stream controls
out_stream_ready_i  in  1  output stream ready
spoof_addr_i  in  L2_AWIDTH_NOAL  spoofed write address
spoof_dest_i  in  STREAM_ID_WIDTH  spoofed write destination
spoof_datasize_i  in  2  spoofed write datasize
spoof_req_i, spoof_gnt_i  in  1  spoofed write request/grant
busy_o  out  1  state != IDLE
err_o  out  1  sticky error; cleared only by rst_i or cmd_clr_i

Behaviour:
- Single clock clk_i; reset is synchronous and active-high (rst_i).
- Reset and cmd_clr_i have identical effect: IDLE, pointers 0, queues empty, counters 0, err_o=0. All outputs are 0 except the IDLE passthrough mux.
- Increment per beat: datasize 00->1, 01->2, 10->4, 11->0. Datasize 11 is illegal and sets err.
- Write event: spoof_req_i & spoof_gnt_i & (spoof_dest_i==INST_ID).
- States: IDLE, REPLAY, DRAIN.
- IDLE:
  - out_stream = in_stream gated by in_stream_dest_i==INST_ID. in_stream_ready_o = out_stream_ready_i. Zero latency.
  - On a write event: r_ds <= spoof_datasize_i; rd_ptr <= spoof_addr_i; wr_ptr <= spoof_addr_i+inc; pending_sot <= 1; go to REPLAY.
- REPLAY / DRAIN, write tracking:
  - in_stream_ready_o=0.
  - On a write event with spoof_addr_i != wr_ptr, push {src=wr_ptr, dst=spoof_addr_i} into the jump queue.
  - Then wr_ptr <= spoof_addr_i+inc.
  - Pushing into a full jump queue sets err and drops the entry, unless a pop happens in the same cycle.
  - A datasize different from r_ds sets err; the write is still tracked.
- Reads:
  - tx_ch_req_o = (rd_ptr != wr_ptr) & (outstanding + fifo_count < FIFO_DEPTH).
  - Address and datasize are held stable until gnt.
- On grant:
  - nxt = rd_ptr+inc; outstanding++.
  - If the queue is non-empty and nxt == head.src: rd_ptr <= head.dst and pop.
  - Bypass: if the queue is empty and a jump is pushed in the same cycle with nxt == its src, rd_ptr <= its dst and the entry is not queued.
  - Otherwise rd_ptr <= nxt.
- Read data:
  - tx_ch_ready_o=1 in REPLAY/DRAIN; credit accounting guarantees FIFO space.
  - tx_ch_valid_i writes the FIFO and decrements outstanding.
  - tx_ch_valid_i with outstanding==0 sets err and the data is dropped.
- FIFO output:
  - out_stream_valid_o = FIFO not empty; datasize = r_ds.
  - sot = pending_sot on the first beat; pending_sot clears on that handshake.
  - First replayed beat appears 1 cycle after tx_ch_valid_i.
- DRAIN:
  - cmd_stop_i in REPLAY goes to DRAIN. Further write events are still tracked.
  - Reads continue until rd_ptr == wr_ptr.
  - eot is asserted on the beat where rd_ptr==wr_ptr, outstanding==0 and fifo_count==1; after that handshake, go to IDLE.
  - If nothing is left (all zero and the FIFO empty), go to IDLE with no eot beat.
- rd_ptr == wr_ptr in REPLAY: no request; hold (buffer-wait).
- cmd_clr_i has priority over every event, including a same-cycle grant or write. In-flight read data after a clear is ignored (ready=0 in IDLE).

Decomposition:
- Package udma_stream_pkg:
  - state enum
  - jump_entry_t {src,dst}
  - function ds_to_inc()
- Sub-module udma_stream_sync_fifo:
  - parametrised width/depth, synchronous active-high reset
  - instantiated twice: data FIFO and jump queue
  - exposes count/full/empty and allows simultaneous push and pop when full

Test Plan:
- Contiguous writes 0x100,0x104,0x108 (ds=10) -> reads at 0x100,0x104,0x108; 3 out beats; sot on the first only; no err.
- Writes 0x100,0x104 then 0x200 -> reads 0x100,0x104,0x200; jump popped when nxt==0x108.
- Backpressure with out_stream_ready_i=0, FIFO_DEPTH=4, 8 pending writes -> exactly 4 grants, then tx_ch_req_o=0 until a pop.
- JUMP_DEPTH=1 with two unread jumps -> err_o=1 sticky until cmd_clr_i.
- Grant at rd_ptr=0x104 (last word, wr_ptr=0x108) in the same cycle as a write at 0x300 -> bypass: next read 0x300.
- cmd_stop_i with 2 words outstanding -> both delivered, eot on the 2nd, busy_o=0 next cycle. cmd_clr_i mid-grant -> IDLE, addr=0.
